// File: rtl/hdmi_info_frame_pkg.sv
// Shared definitions for the HDMI InfoFrame packet sources.
// Contents:
//   - InfoFrame type codes, the maximum payload length and the engine FSM state type.
//   - pack_header: builds the 3-byte header {length, version, 1'b1, type}.
//   - header_sum:  8-bit sum of the three header bytes (checksum seed).
//   - sub_offset:  bit offset of payload byte idx inside the 224-bit sub bus.
package hdmi_info_frame_pkg;

    localparam int unsigned MAX_PAYLOAD = 27;

    localparam logic [6:0] VENDOR = 7'h01;
    localparam logic [6:0] AVI    = 7'h02;
    localparam logic [6:0] SPD    = 7'h03;
    localparam logic [6:0] AUDIO  = 7'h04;

    typedef enum logic [1:0] {
        StIdle,
        StSum,
        StSwap
    } frame_state_e;

    function automatic logic [23:0] pack_header(input logic [4:0] length,
                                                input logic [7:0] version,
                                                input logic [6:0] frame_type);
        return {3'b000, length, version, 1'b1, frame_type};
    endfunction

    function automatic logic [7:0] header_sum(input logic [23:0] hdr);
        return hdr[7:0] + hdr[15:8] + hdr[23:16];
    endfunction

    // Bytes are grouped seven per 56-bit subpacket.
    function automatic int unsigned sub_offset(input int unsigned idx);
        return (idx / 7) * 56 + (idx % 7) * 8;
    endfunction

endpackage

// File: rtl/info_frame_checksum_serial.sv
// Serial InfoFrame checksum: accumulates one payload byte per clock.
// Ports:
//   clk_pixel, reset - clock, asynchronous active-high reset
//   start            - load accumulator with hdr_sum and begin at byte index 1
//   hdr_sum          - sum of the three header bytes
//   data             - payload byte selected by idx
//   idx              - index of the byte being accumulated this cycle
//   last             - this cycle accumulates byte LENGTH
//   done             - all LENGTH bytes accumulated (cleared by start)
//   checksum         - two's-complement of the accumulator
module info_frame_checksum_serial #(
    parameter int unsigned LENGTH = 10
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] hdr_sum,
    input  logic [7:0] data,
    output logic [4:0] idx,
    output logic       last,
    output logic       done,
    output logic [7:0] checksum
);

    logic [7:0] acc_q;
    logic [4:0] cnt_q;
    logic       running_q;
    logic       done_q;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            acc_q     <= 8'd0;
            cnt_q     <= 5'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (start) begin
            acc_q     <= hdr_sum;
            cnt_q     <= 5'd1;
            running_q <= 1'b1;
            done_q    <= 1'b0;
        end else if (running_q) begin
            acc_q <= acc_q + data;
            cnt_q <= cnt_q + 5'd1;
            if (last) begin
                running_q <= 1'b0;
                done_q    <= 1'b1;
            end
        end
    end

    assign idx      = cnt_q;
    assign last     = running_q && (cnt_q == 5'(LENGTH));
    assign done     = done_q;
    assign checksum = 8'd0 - acc_q;

endmodule

// File: rtl/info_frame_engine.sv
// Runtime-programmable, double-buffered HDMI InfoFrame source.
// Payload bytes are written into a shadow bank; commit computes the checksum
// serially and then publishes shadow + checksum into the active bank in one edge.
// Ports:
//   clk_pixel, reset        - pixel clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data   - shadow byte write (index 1..LENGTH, only while idle)
//   commit                  - start checksum and publish
//   hold                    - defer publish while the assembler is mid-packet
//   busy                    - commit accepted, publish pending
//   valid                   - active bank holds a committed frame
//   generation              - publish count, wraps at 256
//   header                  - constant {byte2, byte1, byte0}
//   sub                     - active bank, byte 0 = checksum
module info_frame_engine
    import hdmi_info_frame_pkg::*;
#(
    parameter logic [6:0] TYPE    = AUDIO,
    parameter logic [7:0] VERSION = 8'd1,
    parameter logic [4:0] LENGTH  = 5'd10
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [7:0]   wr_data,
    input  logic         commit,
    input  logic         hold,
    output logic         busy,
    output logic         valid,
    output logic [7:0]   generation,
    output logic [23:0]  header,
    output logic [223:0] sub
);

    if (LENGTH < 5'd1 || 32'(LENGTH) > MAX_PAYLOAD) begin : g_bad_length
        $error("info_frame_engine: LENGTH must be 1..27");
    end

    localparam int unsigned Len = 32'(LENGTH);
    localparam logic [23:0] Hdr = pack_header(LENGTH, VERSION, TYPE);

    frame_state_e state_q, state_d;

    logic [7:0] shadow_q [Len];
    logic [7:0] active_q [Len + 1];
    logic       valid_q;
    logic [7:0] generation_q;

    logic       wr_ok;
    logic       cs_start;
    logic       publish;
    logic [4:0] cs_idx;
    logic       cs_last;
    logic       cs_done;
    logic [7:0] cs_checksum;
    logic [7:0] sum_byte;

    // FSM: state register
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (commit)  state_d = StSum;
            StSum:   if (cs_last) state_d = StSwap;
            StSwap:  if (!hold)   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (state_q != StIdle);
        cs_start = (state_q == StIdle) && commit;
        publish  = (state_q == StSwap) && !hold && cs_done;
    end

    // A write on the commit edge still lands before byte 1 is read.
    assign wr_ok = wr_en && !busy && (wr_addr != 5'd0) && (wr_addr <= LENGTH);

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < Len; i++) shadow_q[i] <= 8'd0;
        end else if (wr_ok) begin
            for (int unsigned i = 1; i <= Len; i++) begin
                if (wr_addr == 5'(i)) shadow_q[i - 1] <= wr_data;
            end
        end
    end

    always_comb begin
        sum_byte = 8'd0;
        for (int unsigned i = 1; i <= Len; i++) begin
            if (cs_idx == 5'(i)) sum_byte = shadow_q[i - 1];
        end
    end

    info_frame_checksum_serial #(
        .LENGTH(Len)
    ) u_checksum (
        .clk_pixel(clk_pixel),
        .reset    (reset),
        .start    (cs_start),
        .hdr_sum  (header_sum(Hdr)),
        .data     (sum_byte),
        .idx      (cs_idx),
        .last     (cs_last),
        .done     (cs_done),
        .checksum (cs_checksum)
    );

    // Whole active bank updates in the single publish edge.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i <= Len; i++) active_q[i] <= 8'd0;
            valid_q      <= 1'b0;
            generation_q <= 8'd0;
        end else if (publish) begin
            active_q[0] <= cs_checksum;
            for (int unsigned i = 1; i <= Len; i++) active_q[i] <= shadow_q[i - 1];
            valid_q      <= 1'b1;
            generation_q <= generation_q + 8'd1;
        end
    end

    always_comb begin
        sub = '0;
        for (int unsigned i = 0; i <= Len; i++) begin
            sub[sub_offset(i) +: 8] = active_q[i];
        end
    end

    assign valid      = valid_q;
    assign generation = generation_q;
    assign header     = Hdr;

endmodule

// File: tb/tb_info_frame_engine.sv
// Randomised + directed bench for info_frame_engine (TYPE=4, VERSION=1, LENGTH=10).
// A transaction-level model tracks shadow/active banks and publish timing.
module tb_info_frame_engine;

    localparam int L = 10;
    localparam logic [7:0] HB0 = 8'h84;
    localparam logic [7:0] HB1 = 8'h01;
    localparam logic [7:0] HB2 = 8'h0A;

    logic         clk_pixel = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         commit;
    logic         hold;
    logic         busy;
    logic         valid;
    logic [7:0]   generation;
    logic [23:0]  header;
    logic [223:0] sub;

    info_frame_engine #(
        .TYPE   (7'd4),
        .VERSION(8'd1),
        .LENGTH (5'd10)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .commit    (commit),
        .hold      (hold),
        .busy      (busy),
        .valid     (valid),
        .generation(generation),
        .header    (header),
        .sub       (sub)
    );

    always #5 clk_pixel = ~clk_pixel;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_shadow [0:27];
    logic [7:0] m_active [0:27];
    logic       m_valid;
    logic [7:0] m_gen;
    logic       m_busy;
    int         m_left;

    task automatic check(input string tag, input logic [223:0] got, input logic [223:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 28; i++) begin
            m_shadow[i] = 8'd0;
            m_active[i] = 8'd0;
        end
        m_valid = 1'b0;
        m_gen   = 8'd0;
        m_busy  = 1'b0;
        m_left  = 0;
    endtask

    function automatic logic [223:0] model_sub();
        logic [223:0] r;
        for (int i = 0; i < 28; i++) r[i*8 +: 8] = m_active[i];
        return r;
    endfunction

    // One rising edge of frame-level behaviour.
    task automatic model_edge();
        logic [7:0] s;
        if (m_busy) begin
            if (m_left > 0) begin
                m_left--;
            end else if (!hold) begin
                s = HB0 + HB1 + HB2;
                for (int i = 1; i <= L; i++) begin
                    m_active[i] = m_shadow[i];
                    s = s + m_shadow[i];
                end
                m_active[0] = 8'd0 - s;
                m_valid = 1'b1;
                m_gen   = m_gen + 8'd1;
                m_busy  = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr >= 5'd1 && wr_addr <= 5'(L)) m_shadow[wr_addr] = wr_data;
            if (commit) begin
                m_busy = 1'b1;
                m_left = L;
            end
        end
    endtask

    task automatic compare_all();
        check("busy", 224'(busy), 224'(m_busy));
        check("valid", 224'(valid), 224'(m_valid));
        check("generation", 224'(generation), 224'(m_gen));
        check("header", 224'(header), 224'(24'h0A0184));
        check("sub", sub, model_sub());
    endtask

    task automatic check_sum_zero();
        logic [7:0] s;
        s = HB0 + HB1 + HB2;
        for (int i = 0; i <= L; i++) s = s + sub[i*8 +: 8];
        if (valid) check("sum_zero", 224'(s), 224'(0));
    endtask

    task automatic step();
        @(posedge clk_pixel);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 reset = 1'b0;
    endtask

    int busy_cnt;

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 8'd0;
        commit  = 1'b0;
        hold    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_pixel);
        #1;
        compare_all();
        reset = 1'b0;

        // 1: empty payload frame
        commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (11) step();
        check("t1_checksum", 224'(sub[7:0]), 224'(8'h71));
        check("t1_valid", 224'(valid), 224'(1'b1));
        check_sum_zero();

        // 2: byte 1 = 01, busy exactly 11 cycles
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'h01;
        step();
        wr_en = 1'b0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (busy) busy_cnt++;
        end
        check("t2_byte1", 224'(sub[15:8]), 224'(8'h01));
        check("t2_checksum", 224'(sub[7:0]), 224'(8'h70));
        check("t2_busy_len", 224'(busy_cnt), 224'(11));
        check_sum_zero();

        // 3: hold defers publish
        hold = 1'b1;
        commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (20) step();
        check("t3_busy_held", 224'(busy), 224'(1'b1));
        check("t3_gen_held", 224'(generation), 224'(8'd2));
        hold = 1'b0;
        step();
        check("t3_busy_fall", 224'(busy), 224'(1'b0));
        check("t3_gen_after", 224'(generation), 224'(8'd3));

        // 4: write/commit while busy dropped; out-of-range addr dropped
        commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (2) step();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 8'hFF; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        repeat (12) step();
        check("t4_byte4", 224'(sub[39:32]), 224'(8'h00));
        check("t4_gen", 224'(generation), 224'(8'd4));
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 8'h5A;
        step();
        wr_en = 1'b0; commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (11) step();
        check("t4_byte11", 224'(sub[95:88]), 224'(8'h00));

        // 5: same-edge write and commit from a clean shadow
        pulse_reset();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h3C; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        repeat (11) step();
        check("t5_byte5", 224'(sub[47:40]), 224'(8'h3C));
        check("t5_checksum", 224'(sub[7:0]), 224'(8'h35));
        check_sum_zero();

        // 6: reset mid-SUM clears everything immediately
        commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (5) step();
        pulse_reset();
        check("t6_valid", 224'(valid), 224'(1'b0));
        check("t6_sub", sub, 224'(0));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = 8'($urandom);
            commit  = ($urandom_range(0, 5) == 0);
            hold    = ($urandom_range(0, 3) == 0);
            step();
            check_sum_zero();
        end
        wr_en = 1'b0; commit = 1'b0; hold = 1'b0;

        // Generation wrap after 256 publishes
        pulse_reset();
        for (int n = 0; n < 256; n++) begin
            commit = 1'b1;
            step();
            commit = 1'b0;
            repeat (11) step();
        end
        check("wrap_gen", 224'(generation), 224'(8'd0));
        check("wrap_valid", 224'(valid), 224'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/info_frame_engine.md
Name: info_frame_engine

Overview:
Runtime-programmable, double-buffered HDMI InfoFrame packet source. Generalises fixed-field InfoFrame generators: TYPE/VERSION/LENGTH are parameters, payload bytes are written at run time into a shadow bank, and the checksum is computed serially. The result is published atomically to the active bank that drives header/sub into the packet assembler.

Parameters:
TYPE, 7'd4, InfoFrame type code; header byte 0 = {1'b1, TYPE}
VERSION, 8'd1, header byte 1
LENGTH, 5'd10, payload length in bytes, legal 1..27; elaboration error otherwise; header byte 2 = {3'b000, LENGTH}

Ports:
clk_pixel  in  1  pixel clock; all state on rising edge
reset  in  1  asynchronous, active-high
wr_en  in  1  shadow byte write strobe
wr_addr  in  5  payload byte index, 1..LENGTH
wr_data  in  8  payload byte value
commit  in  1  start checksum and publish of shadow bank
hold  in  1  defer publish; high while the assembler is mid-packet
busy  out  1  high from commit acceptance until publish
valid  out  1  active bank holds a committed frame
generation  out  8  count of publishes, wraps 255->0
header  out  24  {byte2, byte1, byte0}, constant from parameters
sub  out  224  active bank; byte i at sub[(i/7)*56 + (i%7)*8 +: 8]; byte 0 = checksum

Behaviour:
- Reset (async assert): shadow bytes 1..27 = 0; active bytes 0..27 = 0; valid=0; busy=0; generation=0; FSM=IDLE; accumulator=0. header never depends on reset.
- Bytes with index > LENGTH are always 0 in both banks.
- Writes: accepted only when busy=0 and 1<=wr_addr<=LENGTH. Otherwise silently dropped, including addr 0 and writes while busy.
- FSM IDLE: commit && !busy -> SUM. acc <= H = byte0+byte1+byte2 mod 256; k <= 1.
- Same-edge wr_en and commit in IDLE: the write lands in shadow and is included in the checksum.
- SUM: one edge per byte, acc <= acc + shadow[k], k++. After byte LENGTH -> SWAP. Occupies exactly LENGTH cycles.
- SWAP: checksum = 8'd0 - acc (mod 256).
  - hold=0: active[1..LENGTH] <= shadow, active[0] <= checksum, valid <= 1, generation++, -> IDLE.
  - hold=1: stay in SWAP, outputs unchanged, busy=1.
- busy=1 in SUM and SWAP, registered.
- commit while busy is ignored, not queued.
- Latency: commit sampled at edge E0; active bank updates at edge E(LENGTH+1) with hold low. LENGTH=10 gives 11 cycles.
- Active bank changes only in the single SWAP-exit edge; sub never shows a partially updated frame.
- Invariant: all 3 header bytes + LENGTH+1 active payload bytes sum to 0 mod 256 whenever valid=1.
- Reset mid-SUM or mid-SWAP: abort; everything returns to reset values, including the previously valid active bank.
- Arithmetic: all 8-bit, modulo 256; carries discarded.

Decomposition:
- Shared package hdmi_info_frame_pkg:
  - InfoFrame type constants: VENDOR=7'h01, AVI=7'h02, SPD=7'h03, AUDIO=7'h04.
  - Header-pack function {LENGTH, VERSION, TYPE} -> 24 bits.
  - Byte-index-to-sub-offset function.
  - MAX_PAYLOAD=27.
- One sub-module, info_frame_checksum_serial: accumulator + index counter + done flag. Start input loads H; one byte per cycle; outputs the two's-complement checksum.
- Bank storage and the FSM stay in the top module.

Test Plan:
1. TYPE=4, VERSION=1, LENGTH=10; no writes; commit -> after 11 cycles: header=24'h0A0184, sub[7:0]=8'h71, bytes 1..27=0, valid=1, generation=1.
2. Write addr1=8'h01 (2-channel), commit -> sub[15:8]=8'h01, sub[7:0]=8'h70. busy high exactly 11 cycles. Sum over all bytes = 0.
3. hold=1 held 20 cycles after commit -> busy stays 1, sub/valid/generation unchanged. Release hold -> swap on next edge, busy falls the same edge.
4. While busy: write addr4=8'hFF and pulse commit -> both dropped; sub[39:32]=0; generation increments by 1 only. Write addr11 with LENGTH=10 -> ignored, sub[95:88]=0.
5. Same-edge wr_en(addr5=8'h3C) and commit -> sub[47:40]=8'h3C, checksum 8'h35 (8'h71-8'h3C).
6. Reset asserted at cycle 5 of SUM after a prior valid frame -> immediately valid=0, sub=0, busy=0, generation=0. 256 clean commits -> generation wraps to 0.
